lc3_mem_ctrl: RTL and testbench



---
 rtl/lc3_mem_pkg.sv | 23 ++
 rtl/lc3_mmio_regs.sv | 81 ++++++++
 rtl/lc3_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and address constants for the LC-3 memory controller.
// FSM states, grant encoding and the memory-mapped device register map.
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LDR = 1'b1
   } grant_t;

   localparam logic [15:0] RAM_TOP   = 16'hFE00;
   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard, display and machine-control registers with a registered read mux.
// rd_en/wr_en are single-cycle strobes issued by the controller's ISSUE state.
module lc3_mmio_regs
   import lc3_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_char,
   output logic        dsp_valid,
   output logic [7:0]  dsp_char,
   input  logic        dsp_ready,
   output logic        mcr_run
);

   logic        kbd_full_reg;
   logic [7:0]  kbd_char_reg;
   logic        dsp_valid_reg;
   logic [7:0]  dsp_char_reg;
   logic        mcr_run_reg;
   logic [15:0] rdata_reg;
   logic [15:0] rd_value;
   logic        kbdr_rd;
   logic        ddr_wr;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[14:8];
   assign kbdr_rd      = rd_en && (addr == ADDR_KBDR);
   assign ddr_wr       = wr_en && (addr == ADDR_DDR);

   always_comb begin
      rd_value = 16'h0000;
      case (addr)
         ADDR_KBSR: rd_value = {kbd_full_reg, 15'h0000};
         ADDR_KBDR: rd_value = {8'h00, kbd_char_reg};
         ADDR_DSR:  rd_value = {~dsp_valid_reg, 15'h0000};
         ADDR_MCR:  rd_value = {mcr_run_reg, 15'h0000};
         default:   rd_value = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kbd_full_reg  <= 1'b0;
         kbd_char_reg  <= 8'h00;
         dsp_valid_reg <= 1'b0;
         dsp_char_reg  <= 8'h00;
         mcr_run_reg   <= 1'b1;
         rdata_reg     <= 16'h0000;
      end else begin
         if (rd_en)
            rdata_reg <= rd_value;
         // A fresh keystroke wins over the clear from a coincident KBDR read.
         if (kbd_valid) begin
            kbd_char_reg <= kbd_char;
            kbd_full_reg <= 1'b1;
         end else if (kbdr_rd) begin
            kbd_full_reg <= 1'b0;
         end
         if (ddr_wr && (!dsp_valid_reg || dsp_ready)) begin
            dsp_char_reg  <= wdata[7:0];
            dsp_valid_reg <= 1'b1;
         end else if (dsp_valid_reg && dsp_ready) begin
            dsp_valid_reg <= 1'b0;
         end
         if (wr_en && (addr == ADDR_MCR))
            mcr_run_reg <= wdata[15];
      end
   end

   assign rdata     = rdata_reg;
   assign dsp_valid = dsp_valid_reg;
   assign dsp_char  = dsp_char_reg;
   assign mcr_run   = mcr_run_reg;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: round-robin CPU/loader arbitration, RAM sequencing, MMIO decode.
// Device registers exist only when LC3_MMIO_EN is defined; otherwise 0xFE00+ reads 0.
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int RAM_DEPTH  = 65024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [15:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  ldr_req,
   input  logic                  ldr_we,
   input  logic [15:0]           ldr_addr,
   input  logic [DATA_WIDTH-1:0] ldr_wdata,
   output logic [DATA_WIDTH-1:0] ldr_rdata,
   output logic                  ldr_ready,
   output logic                  ram_cs,
   output logic                  ram_r_w,
   output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   input  logic                  kbd_valid,
   input  logic [7:0]            kbd_char,
   output logic                  dsp_valid,
   output logic [7:0]            dsp_char,
   input  logic                  dsp_ready,
   output logic                  mcr_run
);

   localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);

   state_t                state_reg, state_next;
   grant_t                gnt_reg, gnt_next;
   grant_t                last_grant_reg, last_grant_next;
   logic                  we_reg, we_next;
   logic [15:0]           addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  sel_cpu;
   logic                  is_mmio;
   logic                  mmio_acc;
   logic                  resp;
   logic [15:0]           mmio_rdata;
   logic [DATA_WIDTH-1:0] rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         gnt_reg        <= GNT_CPU;
         last_grant_reg <= GNT_LDR;
         we_reg         <= 1'b0;
         addr_reg       <= 16'h0000;
         wdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         gnt_reg        <= gnt_next;
         last_grant_reg <= last_grant_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
      end
   end

   // On a tie the requester that did not win last time gets the grant.
   assign sel_cpu = cpu_req && (!ldr_req || (last_grant_reg == GNT_LDR));

   always_comb begin
      state_next      = state_reg;
      gnt_next        = gnt_reg;
      last_grant_next = last_grant_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cpu_req || ldr_req) begin
               state_next      = ST_ISSUE;
               gnt_next        = sel_cpu ? GNT_CPU : GNT_LDR;
               last_grant_next = sel_cpu ? GNT_CPU : GNT_LDR;
               we_next         = sel_cpu ? cpu_we    : ldr_we;
               addr_next       = sel_cpu ? cpu_addr  : ldr_addr;
               wdata_next      = sel_cpu ? cpu_wdata : ldr_wdata;
            end
         end
         ST_ISSUE: state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   assign is_mmio  = (addr_reg >= RAM_TOP);
   assign mmio_acc = (state_reg == ST_ISSUE) && is_mmio;
   assign resp     = (state_reg == ST_RESP);

   assign ram_cs    = (state_reg == ST_ISSUE) && !is_mmio;
   assign ram_r_w   = ram_cs && we_reg;
   assign ram_addr  = addr_reg[ADDR_WIDTH-1:0];
   assign ram_wdata = wdata_reg;

   assign rd_data   = we_reg ? '0 : (is_mmio ? DATA_WIDTH'(mmio_rdata) : ram_rdata);
   assign cpu_ready = resp && (gnt_reg == GNT_CPU);
   assign ldr_ready = resp && (gnt_reg == GNT_LDR);
   assign cpu_rdata = cpu_ready ? rd_data : '0;
   assign ldr_rdata = ldr_ready ? rd_data : '0;

`ifdef LC3_MMIO_EN
   lc3_mmio_regs u_mmio (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (mmio_acc && !we_reg),
      .wr_en     (mmio_acc && we_reg),
      .addr      (addr_reg),
      .wdata     (wdata_reg[15:0]),
      .rdata     (mmio_rdata),
      .kbd_valid (kbd_valid),
      .kbd_char  (kbd_char),
      .dsp_valid (dsp_valid),
      .dsp_char  (dsp_char),
      .dsp_ready (dsp_ready),
      .mcr_run   (mcr_run)
   );
`else
   logic unused_mmio;
   assign unused_mmio = ^{kbd_valid, kbd_char, dsp_ready, mmio_acc};
   assign mmio_rdata  = 16'h0000;
   assign dsp_valid   = 1'b0;
   assign dsp_char    = 8'h00;
   assign mcr_run     = 1'b1;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: vector table of single accesses plus
// hand-written sequences for arbitration, devices, MCR and reset abort.
module tb_lc3_mem_ctrl;

`ifdef LC3_MMIO_EN
   localparam bit MMIO_ON = 1'b1;
`else
   localparam bit MMIO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 0, cpu_we = 0;
   logic [15:0] cpu_addr = 0, cpu_wdata = 0;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        ldr_req = 0, ldr_we = 0;
   logic [15:0] ldr_addr = 0, ldr_wdata = 0;
   logic [15:0] ldr_rdata;
   logic        ldr_ready;
   logic        ram_cs, ram_r_w;
   logic [15:0] ram_addr, ram_wdata;
   logic [15:0] ram_rdata = 16'h0000;
   logic        kbd_valid = 0;
   logic [7:0]  kbd_char = 0;
   logic        dsp_valid;
   logic [7:0]  dsp_char;
   logic        dsp_ready = 0;
   logic        mcr_run;

   int total = 0;
   int passed = 0;

   logic [15:0] mem [0:65535];

   always #5 clk = ~clk;

   // Synchronous-read RAM model.
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_r_w) mem[ram_addr] <= ram_wdata;
         else         ram_rdata <= mem[ram_addr];
      end
   end

   lc3_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
      .ram_cs(ram_cs), .ram_r_w(ram_r_w), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .kbd_valid(kbd_valid), .kbd_char(kbd_char),
      .dsp_valid(dsp_valid), .dsp_char(dsp_char), .dsp_ready(dsp_ready),
      .mcr_run(mcr_run)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // One access on a port; returns read data, ready latency and first ram_cs cycle.
   task automatic access(input int port, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, output logic [15:0] rd,
                         output int lat, output int cs_at);
      @(posedge clk); #1;
      if (port == 0) begin
         cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
      end
      lat = 0; cs_at = 0; rd = 16'h0000;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (ram_cs && cs_at == 0) cs_at = n;
         if ((port == 0) ? cpu_ready : ldr_ready) begin
            lat = n;
            rd  = (port == 0) ? cpu_rdata : ldr_rdata;
            break;
         end
      end
      $display("txn port=%0d we=%0d addr=%h wdata=%h rdata=%h lat=%0d cs_at=%0d",
               port, we, addr, wdata, rd, lat, cs_at);
      @(posedge clk); #1;
      cpu_req = 0; ldr_req = 0;
   endtask

   task automatic acc_chk(input string name, input int port, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rd);
      logic [15:0] rd;
      int lat, cs_at;
      access(port, we, addr, wdata, rd, lat, cs_at);
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_lat"}, lat, 3);
   endtask

   task automatic pulse_kbd(input logic [7:0] c);
      @(posedge clk); #1; kbd_valid = 1; kbd_char = c;
      @(posedge clk); #1; kbd_valid = 0;
   endtask

   typedef struct {
      int          port;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      int          exp_cs;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd;
      int lat, cs_at;
      logic [9:0] cpu_mask, ldr_mask;
      int both_cnt, rst_ready;
      logic [15:0] cpu_rd3, ldr_rd6;

      vecs[0]  = '{0, 1'b1, 16'h3000, 16'h1234, 16'h0000, 2};
      vecs[1]  = '{0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 2};
      vecs[2]  = '{1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, 2};
      vecs[3]  = '{1, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 2};
      vecs[4]  = '{1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 2};
      vecs[5]  = '{0, 1'b1, 16'hFDFF, 16'h5555, 16'h0000, 2};
      vecs[6]  = '{0, 1'b0, 16'hFDFF, 16'h0000, 16'h5555, 2};
      vecs[7]  = '{0, 1'b1, 16'h0000, 16'hAAAA, 16'h0000, 2};
      vecs[8]  = '{1, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 2};
      vecs[9]  = '{0, 1'b0, 16'hFE08, 16'h0000, 16'h0000, 0};
      vecs[10] = '{0, 1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 0};
      vecs[11] = '{0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 0};
      vecs[12] = '{0, 1'b0, 16'hFFFE, 16'h0000, MMIO_ON ? 16'h8000 : 16'h0000, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_ldr_ready", ldr_ready, 0);
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_r_w", ram_r_w, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dsp_valid", dsp_valid, 0);
      check("rst_dsp_char", dsp_char, 0);
      check("rst_mcr_run", mcr_run, 1);
      @(posedge clk); #1; rst_n = 1;

      for (int i = 0; i < 13; i++) begin
         access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, cs_at);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_lat", i), lat, 3);
         check($sformatf("vec%0d_cs", i), cs_at, vecs[i].exp_cs);
      end

      // Both requesters held from reset: CPU, LDR, CPU.
      @(posedge clk); #1; rst_n = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      ldr_req = 1; ldr_we = 0; ldr_addr = 16'h4000;
      @(posedge clk); #1; rst_n = 1;
      cpu_mask = '0; ldr_mask = '0; both_cnt = 0; cpu_rd3 = 0; ldr_rd6 = 0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         cpu_mask[n] = cpu_ready;
         ldr_mask[n] = ldr_ready;
         if (cpu_ready && ldr_ready) both_cnt++;
         if (n == 3) cpu_rd3 = cpu_rdata;
         if (n == 6) ldr_rd6 = ldr_rdata;
         $display("arb cycle=%0d cpu_ready=%0d ldr_ready=%0d", n, cpu_ready, ldr_ready);
      end
      @(posedge clk); #1; cpu_req = 0; ldr_req = 0;
      check("arb_cpu_mask", cpu_mask, 10'b10_0000_1000);
      check("arb_ldr_mask", ldr_mask, 10'b00_0100_0000);
      check("arb_both", both_cnt, 0);
      check("arb_cpu_rdata", cpu_rd3, 16'h1234);
      check("arb_ldr_rdata", ldr_rd6, 16'hBEEF);

      // Keyboard
      pulse_kbd(8'h41);
      acc_chk("kbsr_full", 0, 0, 16'hFE00, 0, MMIO_ON ? 16'h8000 : 16'h0000);
      acc_chk("kbdr", 0, 0, 16'hFE02, 0, MMIO_ON ? 16'h0041 : 16'h0000);
      acc_chk("kbsr_empty", 0, 0, 16'hFE00, 0, 16'h0000);

      // Keystroke coinciding with a KBDR read
      pulse_kbd(8'h42);
      @(posedge clk); #1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'hFE02;
      @(posedge clk); #1; kbd_valid = 1; kbd_char = 8'h43;
      @(posedge clk); #1; kbd_valid = 0;
      @(negedge clk);
      check("kbd_coin_ready", cpu_ready, 1);
      check("kbd_coin_rdata", cpu_rdata, MMIO_ON ? 16'h0042 : 16'h0000);
      $display("txn kbdr coincident rdata=%h", cpu_rdata);
      @(posedge clk); #1; cpu_req = 0;
      acc_chk("kbsr_coin", 0, 0, 16'hFE00, 0, MMIO_ON ? 16'h8000 : 16'h0000);
      acc_chk("kbdr_coin", 0, 0, 16'hFE02, 0, MMIO_ON ? 16'h0043 : 16'h0000);

      // Display
      acc_chk("ddr_wr1", 0, 1, 16'hFE06, 16'h0065, 16'h0000);
      check("dsp_valid_set", dsp_valid, MMIO_ON);
      check("dsp_char_65", dsp_char, MMIO_ON ? 8'h65 : 8'h00);
      acc_chk("dsr_busy", 0, 0, 16'hFE04, 0, 16'h0000);
      acc_chk("ddr_wr2", 0, 1, 16'hFE06, 16'h0066, 16'h0000);
      check("dsp_char_kept", dsp_char, MMIO_ON ? 8'h65 : 8'h00);
      @(posedge clk); #1; dsp_ready = 1;
      @(posedge clk); #1; dsp_ready = 0;
      @(negedge clk);
      check("dsp_valid_clr", dsp_valid, 0);
      acc_chk("dsr_idle", 0, 0, 16'hFE04, 0, MMIO_ON ? 16'h8000 : 16'h0000);

      // Machine control
      access(0, 1, 16'hFFFE, 16'h0000, rd, lat, cs_at);
      check("mcr_wr_lat", lat, 3);
      check("mcr_run_clr", mcr_run, MMIO_ON ? 1'b0 : 1'b1);
      acc_chk("ldr_halted", 1, 0, 16'h3000, 0, 16'h1234);
      @(posedge clk); #1; rst_n = 0;
      @(negedge clk);
      check("mcr_run_rst", mcr_run, 1);
      @(posedge clk); #1; rst_n = 1;

      // Reset during ISSUE of a core read
      @(posedge clk); #1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_issue_cs", ram_cs, 1);
      rst_n = 0;
      rst_ready = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (cpu_ready || ldr_ready) rst_ready++;
      end
      cpu_req = 0;
      check("abort_no_ready", rst_ready, 0);
      check("abort_cs", ram_cs, 0);
      @(posedge clk); #1; rst_n = 1;
      acc_chk("after_abort", 0, 0, 16'h3000, 0, 16'h1234);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
